// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard detection and control.
//   Combinational forwarding selects for the two ID-stage sources, load-use
//   stall detection, taken-branch flushing and data-memory wait stalls,
//   sequenced by a small RUN / LDUSE / MWAIT state machine, plus two
//   saturating performance counters (stall cycles, flush cycles).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ID_rs1_i/ID_rs2_i, ID_uses_*   ID-stage sources and whether they are read
//   EX_rd_i, EX_MemRead_i,
//   EX_RegWrite_i                  EX-stage destination / load / write enable
//   MEM_rd_i, MEM_RegWrite_i       MEM-stage destination / write enable
//   EX_branch_taken_i              branch or jump resolved taken in EX
//   MEM_busy_i                     data memory not ready this cycle
//   *_stall_o, *_flush_o           pipeline register hold / clear controls
//   ID_forwardA_o/ID_forwardB_o    forward selects for the ID/EX register
//   stall_cnt_o, flush_cnt_o       saturating performance counters

package hazard_pkg;
    typedef enum logic [1:0] {
        FW_NONE = 2'b00,
        FW_WB   = 2'b01,
        FW_MEM  = 2'b10
    } fw_sel_e;
endpackage

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           ID_rs1_i,
    input  logic [4:0]           ID_rs2_i,
    input  logic                 ID_uses_rs1_i,
    input  logic                 ID_uses_rs2_i,
    input  logic [4:0]           EX_rd_i,
    input  logic                 EX_MemRead_i,
    input  logic                 EX_RegWrite_i,
    input  logic [4:0]           MEM_rd_i,
    input  logic                 MEM_RegWrite_i,
    input  logic                 EX_branch_taken_i,
    input  logic                 MEM_busy_i,
    output logic                 PC_stall_o,
    output logic                 IFID_stall_o,
    output logic                 IDEX_stall_o,
    output logic                 EXMEM_stall_o,
    output logic                 IFID_flush_o,
    output logic                 IDEX_flush_o,
    output fw_sel_e              ID_forwardA_o,
    output fw_sel_e              ID_forwardB_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        LDUSE = 2'b01,
        MWAIT = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 lu;

    // EX result is younger than MEM result, so it wins when both match.
    function automatic fw_sel_e fw_sel(input logic [4:0] rs, input logic used,
                                       input logic [4:0] ex_rd, input logic ex_wr,
                                       input logic [4:0] mem_rd, input logic mem_wr);
        fw_sel_e sel;
        sel = FW_NONE;
        if (used) begin
            if (ex_wr && (ex_rd != 5'd0) && (ex_rd == rs)) begin
                sel = FW_MEM;
            end else if (mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
                sel = FW_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        ID_forwardA_o = fw_sel(ID_rs1_i, ID_uses_rs1_i, EX_rd_i, EX_RegWrite_i,
                               MEM_rd_i, MEM_RegWrite_i);
        ID_forwardB_o = fw_sel(ID_rs2_i, ID_uses_rs2_i, EX_rd_i, EX_RegWrite_i,
                               MEM_rd_i, MEM_RegWrite_i);
    end

    always_comb begin
        lu = EX_MemRead_i && (EX_rd_i != 5'd0) &&
             ((ID_uses_rs1_i && (ID_rs1_i == EX_rd_i)) ||
              (ID_uses_rs2_i && (ID_rs2_i == EX_rd_i)));
    end

    // Next state and controls. Outputs are gated by rst_n so that an
    // asserted reset silences all controls immediately, not at the next edge.
    always_comb begin
        state_d       = state_q;
        PC_stall_o    = 1'b0;
        IFID_stall_o  = 1'b0;
        IDEX_stall_o  = 1'b0;
        EXMEM_stall_o = 1'b0;
        IFID_flush_o  = 1'b0;
        IDEX_flush_o  = 1'b0;

        if (MEM_busy_i) begin
            state_d = MWAIT;
        end else begin
            state_d = RUN;
            if ((state_q == RUN) && !EX_branch_taken_i && lu) begin
                state_d = LDUSE;
            end
        end

        if (rst_n) begin
            if (MEM_busy_i) begin
                PC_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_stall_o  = 1'b1;
                EXMEM_stall_o = 1'b1;
            end else if (EX_branch_taken_i) begin
                IFID_flush_o = 1'b1;
                IDEX_flush_o = 1'b1;
            end else if (lu && (state_q == RUN)) begin
                PC_stall_o   = 1'b1;
                IFID_stall_o = 1'b1;
                IDEX_flush_o = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (PC_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (IFID_flush_o && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// cycles compared against a behavioural model of the hazard rules.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] ID_rs1_i, ID_rs2_i, EX_rd_i, MEM_rd_i;
    logic       ID_uses_rs1_i, ID_uses_rs2_i, EX_MemRead_i, EX_RegWrite_i;
    logic       MEM_RegWrite_i, EX_branch_taken_i, MEM_busy_i;
    logic       PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o;
    logic       IFID_flush_o, IDEX_flush_o;
    fw_sel_e    ID_forwardA_o, ID_forwardB_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic       s4_PC_stall, s4_IFID_stall, s4_IDEX_stall, s4_EXMEM_stall;
    logic       s4_IFID_flush, s4_IDEX_flush;
    fw_sel_e    s4_fwA, s4_fwB;
    logic [3:0] s4_stall_cnt, s4_flush_cnt;

    hazard_unit #(.CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
        .EX_rd_i(EX_rd_i), .EX_MemRead_i(EX_MemRead_i), .EX_RegWrite_i(EX_RegWrite_i),
        .MEM_rd_i(MEM_rd_i), .MEM_RegWrite_i(MEM_RegWrite_i),
        .EX_branch_taken_i(EX_branch_taken_i), .MEM_busy_i(MEM_busy_i),
        .PC_stall_o(PC_stall_o), .IFID_stall_o(IFID_stall_o),
        .IDEX_stall_o(IDEX_stall_o), .EXMEM_stall_o(EXMEM_stall_o),
        .IFID_flush_o(IFID_flush_o), .IDEX_flush_o(IDEX_flush_o),
        .ID_forwardA_o(ID_forwardA_o), .ID_forwardB_o(ID_forwardB_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    hazard_unit #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .ID_rs1_i(ID_rs1_i), .ID_rs2_i(ID_rs2_i),
        .ID_uses_rs1_i(ID_uses_rs1_i), .ID_uses_rs2_i(ID_uses_rs2_i),
        .EX_rd_i(EX_rd_i), .EX_MemRead_i(EX_MemRead_i), .EX_RegWrite_i(EX_RegWrite_i),
        .MEM_rd_i(MEM_rd_i), .MEM_RegWrite_i(MEM_RegWrite_i),
        .EX_branch_taken_i(EX_branch_taken_i), .MEM_busy_i(MEM_busy_i),
        .PC_stall_o(s4_PC_stall), .IFID_stall_o(s4_IFID_stall),
        .IDEX_stall_o(s4_IDEX_stall), .EXMEM_stall_o(s4_EXMEM_stall),
        .IFID_flush_o(s4_IFID_flush), .IDEX_flush_o(s4_IDEX_flush),
        .ID_forwardA_o(s4_fwA), .ID_forwardB_o(s4_fwB),
        .stall_cnt_o(s4_stall_cnt), .flush_cnt_o(s4_flush_cnt)
    );

    // {PC_stall, IFID_stall, IDEX_stall, EXMEM_stall, IFID_flush, IDEX_flush}
    logic [5:0] ctl_o;
    assign ctl_o = {PC_stall_o, IFID_stall_o, IDEX_stall_o, EXMEM_stall_o,
                    IFID_flush_o, IDEX_flush_o};

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model. A load-use stall may only be raised when the
    // previous cycle neither waited on memory nor itself raised one.
    bit      m_armed;
    int      m_stall, m_flush, m_stall4, m_flush4;
    bit [5:0] e_ctl;
    bit      e_lu_stall;
    fw_sel_e e_fa, e_fb;

    function automatic fw_sel_e ref_fw(input logic [4:0] rs, input logic used);
        if (!used) return FW_NONE;
        if (EX_RegWrite_i && EX_rd_i != 0 && EX_rd_i == rs) return FW_MEM;
        if (MEM_RegWrite_i && MEM_rd_i != 0 && MEM_rd_i == rs) return FW_WB;
        return FW_NONE;
    endfunction

    task automatic model_eval();
        bit hz;
        hz = EX_MemRead_i && EX_rd_i != 0 &&
             ((ID_uses_rs1_i && ID_rs1_i == EX_rd_i) || (ID_uses_rs2_i && ID_rs2_i == EX_rd_i));
        e_lu_stall = 1'b0;
        if (MEM_busy_i)             e_ctl = 6'b111100;
        else if (EX_branch_taken_i) e_ctl = 6'b000011;
        else if (hz && m_armed) begin
            e_ctl = 6'b110001;
            e_lu_stall = 1'b1;
        end else                    e_ctl = 6'b000000;
        e_fa = ref_fw(ID_rs1_i, ID_uses_rs1_i);
        e_fb = ref_fw(ID_rs2_i, ID_uses_rs2_i);
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_ctl[5]) begin
            m_stall  = (m_stall  < 65535) ? m_stall + 1  : m_stall;
            m_stall4 = (m_stall4 < 15)    ? m_stall4 + 1 : m_stall4;
        end
        if (e_ctl[1]) begin
            m_flush  = (m_flush  < 65535) ? m_flush + 1  : m_flush;
            m_flush4 = (m_flush4 < 15)    ? m_flush4 + 1 : m_flush4;
        end
        m_armed = !MEM_busy_i && !e_lu_stall;
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs1_i = 0; ID_rs2_i = 0; ID_uses_rs1_i = 0; ID_uses_rs2_i = 0;
        EX_rd_i = 0; EX_MemRead_i = 0; EX_RegWrite_i = 0;
        MEM_rd_i = 0; MEM_RegWrite_i = 0; EX_branch_taken_i = 0; MEM_busy_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_armed = 1; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        MEM_busy_i = 1; EX_branch_taken_i = 1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctl_o !== 6'b000000) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 000000", ctl_o);
        end
        n_checks++;
        if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o);
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        // EX and MEM both write x5 -> EX wins; with rd = x0 nothing forwards.
        EX_RegWrite_i = 1; EX_rd_i = 5; MEM_RegWrite_i = 1; MEM_rd_i = 5;
        ID_rs1_i = 5; ID_uses_rs1_i = 1;
        #1;
        n_checks++;
        if (ID_forwardA_o !== FW_MEM) begin
            n_fail++; $display("FAIL fw_priority: got %0d expected %0d", ID_forwardA_o, FW_MEM);
        end
        EX_rd_i = 0; MEM_rd_i = 0; ID_rs1_i = 0;
        #1;
        n_checks++;
        if (ID_forwardA_o !== FW_NONE) begin
            n_fail++; $display("FAIL fw_x0: got %0d expected %0d", ID_forwardA_o, FW_NONE);
        end
        for (int i = 0; i < 40; i++) begin
            ID_rs1_i = 5'($urandom_range(0, 3)); ID_rs2_i = 5'($urandom_range(0, 3));
            ID_uses_rs1_i = 1'($urandom); ID_uses_rs2_i = 1'($urandom);
            EX_rd_i = 5'($urandom_range(0, 3)); EX_RegWrite_i = 1'($urandom);
            MEM_rd_i = 5'($urandom_range(0, 3)); MEM_RegWrite_i = 1'($urandom);
            #1;
            model_eval();
            n_checks++;
            if (ID_forwardA_o !== e_fa || ID_forwardB_o !== e_fb) begin
                n_fail++;
                $display("FAIL fw_random: got A=%0d B=%0d expected A=%0d B=%0d",
                         ID_forwardA_o, ID_forwardB_o, e_fa, e_fb);
            end
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_i = 7; ID_rs2_i = 7; ID_uses_rs2_i = 1;
        @(negedge clk);
        n_checks++;
        if (ctl_o !== 6'b110001) begin
            n_fail++; $display("FAIL lu_stall: got %b expected 110001", ctl_o);
        end
        model_eval(); advance();
        @(negedge clk);
        n_checks++;
        if (ctl_o !== 6'b000000 || stall_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL lu_once: got %b cnt %0d expected 000000 cnt 1", ctl_o, stall_cnt_o);
        end
        model_eval(); advance();
        // Back in RUN: a fresh load-use is acted on again.
        @(negedge clk);
        n_checks++;
        if (ctl_o !== 6'b110001) begin
            n_fail++; $display("FAIL lu_rearm: got %b expected 110001", ctl_o);
        end
        model_eval(); advance();
        clear_inputs();
    endtask

    task automatic test_branch_over_lu();
        do_reset();
        EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_i = 3; ID_rs1_i = 3; ID_uses_rs1_i = 1;
        EX_branch_taken_i = 1;
        @(negedge clk);
        n_checks++;
        if (ctl_o !== 6'b000011) begin
            n_fail++; $display("FAIL branch_lu: got %b expected 000011", ctl_o);
        end
        model_eval(); advance();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (flush_cnt_o !== 16'd1 || stall_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL branch_cnt: got %0d/%0d expected flush 1 stall 0", flush_cnt_o, stall_cnt_o);
        end
        model_eval(); advance();
    endtask

    task automatic test_mem_wait();
        do_reset();
        MEM_busy_i = 1; EX_branch_taken_i = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ctl_o !== 6'b111100) begin
                n_fail++; $display("FAIL mwait_stall[%0d]: got %b expected 111100", i, ctl_o);
            end
            model_eval(); advance();
        end
        MEM_busy_i = 0;
        @(negedge clk);
        n_checks++;
        if (ctl_o !== 6'b000011) begin
            n_fail++; $display("FAIL mwait_flush: got %b expected 000011", ctl_o);
        end
        model_eval(); advance();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (stall_cnt_o !== 16'd3 || flush_cnt_o !== 16'd1) begin
            n_fail++; $display("FAIL mwait_cnt: got %0d/%0d expected 3/1", stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        MEM_busy_i = 1;
        for (int i = 0; i < 20; i++) begin
            model_eval(); advance();
        end
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (s4_stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat4: got %0d expected 15", s4_stall_cnt);
        end
        n_checks++;
        if (stall_cnt_o !== 16'd20) begin
            n_fail++; $display("FAIL sat16: got %0d expected 20", stall_cnt_o);
        end
        model_eval(); advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        MEM_busy_i = 1;
        model_eval(); advance();
        model_eval(); advance();
        // Mid-MWAIT, between edges: reset must act without a clock.
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ctl_o !== 6'b000000 || stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL async_rst: got ctl %b cnt %0d/%0d expected 000000 0/0", ctl_o, stall_cnt_o, flush_cnt_o);
        end
        MEM_busy_i = 0;
        EX_MemRead_i = 1; EX_RegWrite_i = 1; EX_rd_i = 9; ID_rs1_i = 9; ID_uses_rs1_i = 1;
        #1 rst_n = 1'b1;
        m_armed = 1; m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
        // A stale MWAIT would suppress this load-use stall.
        #1;
        n_checks++;
        if (ctl_o !== 6'b110001) begin
            n_fail++; $display("FAIL async_rst_run: got %b expected 110001", ctl_o);
        end
        model_eval(); advance();
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            MEM_busy_i        = ($urandom_range(0, 4) == 0);
            EX_branch_taken_i = ($urandom_range(0, 4) == 0);
            EX_MemRead_i      = 1'($urandom);
            EX_RegWrite_i     = 1'($urandom);
            MEM_RegWrite_i    = 1'($urandom);
            ID_uses_rs1_i     = 1'($urandom);
            ID_uses_rs2_i     = 1'($urandom);
            EX_rd_i  = 5'($urandom_range(0, 3));
            MEM_rd_i = 5'($urandom_range(0, 3));
            ID_rs1_i = 5'($urandom_range(0, 3));
            ID_rs2_i = 5'($urandom_range(0, 3));
            model_eval();
            @(negedge clk);
            n_checks++;
            if (ctl_o !== e_ctl) begin
                n_fail++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, ctl_o, e_ctl);
            end
            n_checks++;
            if (ID_forwardA_o !== e_fa || ID_forwardB_o !== e_fb) begin
                n_fail++; $display("FAIL rnd_fw[%0d]: got %0d/%0d expected %0d/%0d",
                                   i, ID_forwardA_o, ID_forwardB_o, e_fa, e_fb);
            end
            n_checks++;
            if (stall_cnt_o !== 16'(m_stall) || flush_cnt_o !== 16'(m_flush) ||
                s4_stall_cnt !== 4'(m_stall4) || s4_flush_cnt !== 4'(m_flush4)) begin
                n_fail++;
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", i,
                         stall_cnt_o, flush_cnt_o, s4_stall_cnt, s4_flush_cnt,
                         m_stall, m_flush, m_stall4, m_flush4);
            end
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_over_lu();
        test_mem_wait();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
